// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the instruction-fetch requester and the
// load/store requester. One transaction is in flight at a time. The winning
// request is latched into the mem_* registers and held until mem_ack. The
// read data is then returned to the owner with a one-cycle ready pulse.
// A RESP cycle follows every completion so the requester can drop or change
// its request before the next arbitration. Data accesses win ties. After
// STARVE_LIMIT consecutive data grants taken while fetch was waiting, fetch
// wins the next tie.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request in
//   if_rdata/if_ready             fetch response out
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_wstrb             data request in
//   dm_rdata/dm_ready             data response out
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wstrb           registered memory request out
//   mem_ack/mem_rdata             memory completion in
//   grant                         one-hot owner {data, fetch}, 00 when idle
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_ready,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]              grant
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_IF = 2'd1,
    ST_GNT_DM = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              starve_cnt_q, starve_cnt_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_WIDTH-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   dm_rdata_q, dm_rdata_d;
  logic                    if_ready_q, if_ready_d;
  logic                    dm_ready_q, dm_ready_d;
  logic [1:0]              grant_q, grant_d;

  // Fetch is starved once the counter reaches the limit while it is waiting.
  logic dm_wins_s;
  assign dm_wins_s = dm_req && !(if_req && (starve_cnt_q == STARVE_MAX));

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;
    grant_d      = grant_q;

    case (state_q)
      ST_IDLE: begin
        grant_d = 2'b00;
        if (dm_wins_s) begin
          state_d     = ST_GNT_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_wstrb_d = dm_wstrb;
          grant_d     = 2'b10;
          // A data win with fetch waiting implies the counter is below the
          // limit, so a plain increment never overshoots.
          if (if_req) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = 4'd0;
          end
        end else if (if_req) begin
          state_d      = ST_GNT_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          mem_wstrb_d  = '0;
          grant_d      = 2'b01;
          starve_cnt_d = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GNT_IF: begin
        if (mem_ack) begin
          if_rdata_d = mem_rdata;
          mem_req_d  = 1'b0;
          if_ready_d = 1'b1;
          state_d    = ST_RESP;
        end else begin
          state_d = ST_GNT_IF;
        end
      end
      ST_GNT_DM: begin
        if (mem_ack) begin
          dm_rdata_d = mem_rdata;
          mem_req_d  = 1'b0;
          dm_ready_d = 1'b1;
          state_d    = ST_RESP;
        end else begin
          state_d = ST_GNT_DM;
        end
      end
      ST_RESP: begin
        // grant keeps the owner for this cycle and clears on the way out.
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        grant_d   = 2'b00;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      grant_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ready_q   <= if_ready_d;
      dm_ready_q   <= dm_ready_d;
      grant_q      <= grant_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = 32'd0;
  logic [31:0] dm_wdata = 32'd0;
  logic [3:0]  dm_wstrb = 4'd0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [1:0]  grant;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Reference model state
  int          starve = 0;
  logic [31:0] exp_if_rdata = 32'd0;
  logic [31:0] exp_dm_rdata = 32'd0;
  bit          last_dm_win;
  int unsigned last_gnt_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_if_ready"}, 32'(if_ready), 32'd0);
    chk({tag, "_dm_ready"}, 32'(dm_ready), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, exp_if_rdata);
    chk({tag, "_dm_rdata"}, dm_rdata, exp_dm_rdata);
  endtask

  // One complete transaction, starting in IDLE with requests already driven.
  task automatic run_txn(input int waits, input logic [31:0] rd, input bit hold);
    bit          dm_win;
    logic [1:0]  g;
    logic [31:0] ea, ew;
    logic [3:0]  es;
    logic        ewe;
    if (if_req && dm_req) dm_win = (starve != LIMIT);
    else dm_win = dm_req;
    if (dm_win && if_req) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
    else starve = 0;
    if (dm_win) begin
      g = 2'b10; ea = dm_addr; ewe = dm_we; ew = dm_wdata; es = dm_wstrb;
    end else begin
      g = 2'b01; ea = if_addr; ewe = 1'b0; ew = 32'd0; es = 4'd0;
    end
    last_dm_win = dm_win;
    step();
    last_gnt_cyc = cyc;
    chk("gnt_grant", 32'(grant), 32'(g));
    chk("gnt_mem_req", 32'(mem_req), 32'd1);
    chk("gnt_mem_addr", mem_addr, ea);
    chk("gnt_mem_we", 32'(mem_we), 32'(ewe));
    chk("gnt_mem_wdata", mem_wdata, ew);
    chk("gnt_mem_wstrb", 32'(mem_wstrb), 32'(es));
    chk("gnt_no_ready", 32'({if_ready, dm_ready}), 32'd0);
    for (int w = 0; w < waits; w++) begin
      step();
      chk("wait_mem_req", 32'(mem_req), 32'd1);
      chk("wait_mem_addr", mem_addr, ea);
      chk("wait_mem_we", 32'(mem_we), 32'(ewe));
      chk("wait_mem_wdata", mem_wdata, ew);
      chk("wait_grant", 32'(grant), 32'(g));
      chk("wait_no_ready", 32'({if_ready, dm_ready}), 32'd0);
    end
    mem_ack = 1'b1;
    mem_rdata = rd;
    step();
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    if (dm_win) exp_dm_rdata = rd;
    else exp_if_rdata = rd;
    chk("resp_if_ready", 32'(if_ready), 32'(!dm_win));
    chk("resp_dm_ready", 32'(dm_ready), 32'(dm_win));
    chk("resp_if_rdata", if_rdata, exp_if_rdata);
    chk("resp_dm_rdata", dm_rdata, exp_dm_rdata);
    chk("resp_mem_req", 32'(mem_req), 32'd0);
    chk("resp_grant", 32'(grant), 32'(g));
    if (!hold) begin
      if (dm_win) dm_req = 1'b0;
      else if_req = 1'b0;
    end
    step();
    chk_idle("post");
  endtask

  bit exp_order [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int unsigned prev_cyc;

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_mem_wstrb", 32'(mem_wstrb), 32'd0);

    // Fetch only, zero-wait memory
    if_req = 1'b1;
    if_addr = 32'h0000_0100;
    run_txn(0, 32'h00A0_0093, 1'b0);

    // Store with three wait cycles
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0200;
    dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
    run_txn(3, 32'h1234_5678, 1'b0);
    step();
    chk("store_single_pulse", 32'({if_ready, dm_ready}), 32'd0);

    // Both requesters held: starvation pattern and 3-cycle throughput
    if_req = 1'b1; if_addr = 32'h0000_0500;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0600;
    dm_wdata = 32'd0; dm_wstrb = 4'd0;
    prev_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      run_txn(0, 32'hA000_0000 + 32'(i), 1'b1);
      chk("starve_order", 32'(last_dm_win), 32'(exp_order[i]));
      if (i > 0) chk("starve_spacing", last_gnt_cyc - prev_cyc, 32'd3);
      prev_cyc = last_gnt_cyc;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    step();

    // Reset while a load waits for its ack
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300;
    step();
    chk("rst_pre_grant", 32'(grant), 32'b10);
    chk("rst_pre_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    dm_req = 1'b0;
    starve = 0;
    exp_if_rdata = 32'd0;
    exp_dm_rdata = 32'd0;
    chk_idle("rst_abort");
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_0BAD;
    step();
    mem_ack = 1'b0;
    chk_idle("rst_late_ack");
    step();
    chk_idle("rst_late_ack2");
    if_req = 1'b1;
    if_addr = 32'h0000_0400;
    run_txn(1, 32'h0000_0013, 1'b0);

    // Spurious ack while idle
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rdata = $urandom;
      step();
      chk_idle("spurious");
    end
    mem_ack = 1'b0;

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      if (!if_req && ($urandom_range(0, 1) == 1)) begin
        if_req = 1'b1;
        if_addr = $urandom;
      end
      if (!dm_req && ($urandom_range(0, 1) == 1)) begin
        dm_req = 1'b1;
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom;
        dm_wdata = $urandom;
        dm_wstrb = 4'($urandom_range(0, 15));
      end
      if (!if_req && !dm_req) begin
        if_req = 1'b1;
        if_addr = $urandom;
      end
      run_txn(int'($urandom_range(0, 3)), $urandom, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
